// File: rtl/rcv_ctrl_pkg.sv
// Shared state encoding and default frame geometry for the receive-path controller.
package rcv_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    CHECK = 3'd2,
    LOAD  = 3'd3,
    ERR   = 3'd4
  } rcv_state_t;

  localparam int DEF_CLKS_PER_BIT = 10;
  localparam int DEF_DATA_BITS    = 8;

endpackage

// File: rtl/flex_counter.sv
// Up-counter 1..rollover_val wrapping back to 1; clear forces 0 and wins over enable.
// Count updates on the edge after count_enable is seen.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out
);

  logic [NUM_CNT_BITS-1:0] count_q;
  logic [NUM_CNT_BITS-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      if (count_q == rollover_val) count_d = NUM_CNT_BITS'(1);
      else                         count_d = count_q + NUM_CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_out = count_q;

endmodule

// File: rtl/rcv_frame_ctrl.sv
// Receive frame sequencer: times bit cells, strobes the shifter, checks the stop bit.
// Strobe n lands CLKS_PER_BIT*n cycles after the start edge; load/error follows two cycles after the last strobe.
module rcv_frame_ctrl
  import rcv_ctrl_pkg::*;
#(
  parameter  int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter  int DATA_BITS    = DEF_DATA_BITS,
  localparam int TMR_BITS     = $clog2(CLKS_PER_BIT + 1),
  localparam int BIT_BITS     = $clog2(DATA_BITS + 2)
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start_detected,
  input  logic                abort,
  input  logic                stop_bit,
  output logic                shift_strobe,
  output logic                load_buffer,
  output logic                framing_error,
  output logic                busy,
  output logic [BIT_BITS-1:0] bit_count
);

  localparam logic [TMR_BITS-1:0] TMR_MAX  = TMR_BITS'(CLKS_PER_BIT);
  localparam logic [BIT_BITS-1:0] BIT_ROLL = BIT_BITS'(DATA_BITS + 1);
  localparam logic [BIT_BITS-1:0] LAST_BIT = BIT_BITS'(DATA_BITS);

  rcv_state_t          state_q, state_d;
  logic                framing_error_q, framing_error_d;
  logic [TMR_BITS-1:0] tmr_count;
  logic                cnt_clear;

  assign cnt_clear    = (state_q == IDLE) || abort;
  assign shift_strobe = (state_q == RUN) && (tmr_count == TMR_MAX);

  flex_counter #(.NUM_CNT_BITS(TMR_BITS)) u_bit_tmr (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (cnt_clear),
    .count_enable (state_q == RUN),
    .rollover_val (TMR_MAX),
    .count_out    (tmr_count)
  );

  flex_counter #(.NUM_CNT_BITS(BIT_BITS)) u_bit_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (cnt_clear),
    .count_enable (shift_strobe),
    .rollover_val (BIT_ROLL),
    .count_out    (bit_count)
  );

  always_comb begin
    state_d         = state_q;
    framing_error_d = framing_error_q;
    load_buffer     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_detected) begin
          state_d         = RUN;
          framing_error_d = 1'b0;
        end
      end
      RUN: begin
        // the strobe taken with bit_count==DATA_BITS samples the stop bit
        if (shift_strobe && (bit_count == LAST_BIT)) state_d = CHECK;
      end
      CHECK: begin
        if (stop_bit) begin
          state_d = LOAD;
        end else begin
          state_d         = ERR;
          framing_error_d = 1'b1;
        end
      end
      LOAD: begin
        load_buffer = !abort;
        state_d     = IDLE;
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d         = IDLE;
      framing_error_d = framing_error_q;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q         <= IDLE;
      framing_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      framing_error_q <= framing_error_d;
    end
  end

  assign framing_error = framing_error_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_rcv_frame_ctrl.sv
// Directed bench for rcv_frame_ctrl with a strobe/load scoreboard checked on the falling edge.
module tb_rcv_frame_ctrl;

  localparam int CPB = 10;
  localparam int DB  = 8;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       start_detected = 1'b0;
  logic       abort = 1'b0;
  logic       stop_bit = 1'b0;
  logic       shift_strobe;
  logic       load_buffer;
  logic       framing_error;
  logic       busy;
  logic [3:0] bit_count;

  rcv_frame_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .start_detected (start_detected),
    .abort          (abort),
    .stop_bit       (stop_bit),
    .shift_strobe   (shift_strobe),
    .load_buffer    (load_buffer),
    .framing_error  (framing_error),
    .busy           (busy),
    .bit_count      (bit_count)
  );

  always #5 clk = ~clk;

  // cyc holds the index of the most recent rising edge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int at;
    int bc;
  } ev_t;

  ev_t strobe_q[$];
  int  load_q[$];
  ev_t mon_e;
  int  mon_l;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (n_rst) begin
      if (shift_strobe) begin
        if (strobe_q.size() == 0) begin
          check("strobe_unexpected", 32'(shift_strobe), 32'd0);
        end else begin
          mon_e = strobe_q.pop_front();
          check("strobe_cycle", cyc, mon_e.at);
          check("strobe_bit_count", 32'(bit_count), mon_e.bc);
        end
      end
      if (load_buffer) begin
        if (load_q.size() == 0) begin
          check("load_unexpected", 32'(load_buffer), 32'd0);
        end else begin
          mon_l = load_q.pop_front();
          check("load_cycle", cyc, mon_l);
        end
      end
    end
  end

  // strobe n in the cycle after edge k+n*CPB; load two cycles after the last strobe
  task automatic push_frame(input int k, input int nstrobes, input bit good);
    ev_t e;
    for (int n = 1; n <= nstrobes; n++) begin
      e.at = k + n * CPB;
      e.bc = n - 1;
      strobe_q.push_back(e);
    end
    if (good) load_q.push_back(k + (DB + 1) * CPB + 2);
  endtask

  task automatic start_frame(output int k);
    start_detected = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    start_detected = 1'b0;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k, k2, k3, k4, k5;

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_strobe", 32'(shift_strobe), 32'd0);
    check("rst_load", 32'(load_buffer), 32'd0);
    check("rst_ferr", 32'(framing_error), 32'd0);
    check("rst_bit_count", 32'(bit_count), 32'd0);
    n_rst = 1'b1;
    @(negedge clk);

    // good frame
    stop_bit = 1'b1;
    start_frame(k);
    push_frame(k, DB + 1, 1'b1);
    wait_to(k + 1);
    check("busy_run", 32'(busy), 32'd1);
    wait_to(k + (DB + 1) * CPB + 1);
    check("check_bit_count", 32'(bit_count), DB + 1);
    check("check_no_strobe", 32'(shift_strobe), 32'd0);
    wait_to(k + (DB + 1) * CPB + 3);
    check("busy_idle", 32'(busy), 32'd0);
    check("ferr_good", 32'(framing_error), 32'd0);

    // back-to-back frame with a bad stop bit
    stop_bit = 1'b0;
    start_frame(k2);
    push_frame(k2, DB + 1, 1'b0);
    wait_to(k2 + (DB + 1) * CPB + 2);
    check("ferr_set", 32'(framing_error), 32'd1);
    check("busy_err", 32'(busy), 32'd1);
    wait_to(k2 + (DB + 1) * CPB + 3);
    check("busy_after_err", 32'(busy), 32'd0);
    wait_to(k2 + (DB + 1) * CPB + 10);
    check("ferr_hold", 32'(framing_error), 32'd1);

    // next start clears the error; abort after strobe 4
    start_frame(k3);
    check("ferr_clear", 32'(framing_error), 32'd0);
    push_frame(k3, 4, 1'b0);
    wait_to(k3 + 4 * CPB + 2);
    check("pre_abort_bit_count", 32'(bit_count), 32'd4);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("busy_abort", 32'(busy), 32'd0);
    check("abort_bit_count", 32'(bit_count), 32'd0);

    abort = 1'b1;
    start_detected = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start_detected = 1'b0;
    check("abort_wins", 32'(busy), 32'd0);
    repeat (120) @(negedge clk);
    check("idle_after_abort", 32'(busy), 32'd0);

    // repeated start pulses during RUN are ignored
    stop_bit = 1'b1;
    start_frame(k4);
    push_frame(k4, DB + 1, 1'b1);
    for (int t = 5; t < 90; t += 17) begin
      wait_to(k4 + t);
      start_detected = 1'b1;
      @(negedge clk);
      start_detected = 1'b0;
    end
    wait_to(k4 + (DB + 1) * CPB + 3);
    check("busy_restart", 32'(busy), 32'd0);
    check("ferr_restart", 32'(framing_error), 32'd0);

    // asynchronous reset mid-frame
    start_frame(k5);
    push_frame(k5, 2, 1'b0);
    wait_to(k5 + 25);
    #1 n_rst = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_bit_count", 32'(bit_count), 32'd0);
    check("arst_strobe", 32'(shift_strobe), 32'd0);
    @(negedge clk);
    #1 n_rst = 1'b1;
    repeat (30) @(negedge clk);
    check("arst_idle", 32'(busy), 32'd0);

    check("strobes_left", strobe_q.size(), 32'd0);
    check("loads_left", load_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
